// File: rtl/keypad_scan_4x4.sv
// keypad_scan_4x4: 4x4 matrix keypad scanner with frame-based debounce and one-clock press strobe
// Ports:
//    ck      system clock, rising edge
//    R       asynchronous active-low reset
//    Row     keypad rows, active-low, asynchronous to ck
//    Col     keypad columns, active-low, one column driven at a time
//    Key     code {row_idx, col_idx} of the last accepted key
//    Valid   one-cycle pulse when a new press is accepted
//    Pressed high from press acceptance until release acceptance
module keypad_scan_4x4 #(
   parameter int CLK_DIV    = 50_000,
   parameter int DEB_FRAMES = 4
) (
   input  logic       ck,
   input  logic       R,
   input  logic [3:0] Row,
   output logic [3:0] Col,
   output logic [3:0] Key,
   output logic       Valid,
   output logic       Pressed
);
   localparam logic [15:0] CNT_TOP = 16'(CLK_DIV - 1);
   localparam logic [3:0]  DEB     = 4'(DEB_FRAMES);
   typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} state_t;
   state_t      state_q;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  row_s1_q, row_s2_q;
   logic [1:0]  col_idx_q;
   logic [1:0]  acc_q, tot;
   logic [3:0]  acc_code_q, f_code, cand_q, fcnt_q, fcnt_inc, act;
   logic [2:0]  n_act, sum;
   logic [1:0]  row_hit;
   logic        tick, frame_end, one, none;
   assign Col = ~(4'b0001 << col_idx_q);
   // The active-bit count saturates at 2: the frame only needs NONE / ONE / MULTI.
   always_comb begin
      tick      = cnt_q == CNT_TOP;
      cnt_d     = tick ? '0 : cnt_q + 16'd1;
      frame_end = tick && col_idx_q == 2'd3;
      act       = ~row_s2_q;
      n_act     = {2'b0, act[0]} + {2'b0, act[1]} + {2'b0, act[2]} + {2'b0, act[3]};
      row_hit   = act[0] ? 2'd0 : act[1] ? 2'd1 : act[2] ? 2'd2 : 2'd3;
      sum       = {1'b0, acc_q} + n_act;
      tot       = sum > 3'd1 ? 2'd2 : sum[1:0];
      // When the frame total is one, the single hit is either in this column or already recorded.
      f_code    = n_act != 3'd0 ? {row_hit, col_idx_q} : acc_code_q;
      one       = tot == 2'd1;
      none      = tot == 2'd0;
      fcnt_inc  = fcnt_q + 4'd1;
   end
   always_ff @(posedge ck or negedge R) begin
      if (!R) begin
         cnt_q      <= '0;
         row_s1_q   <= 4'hf;
         row_s2_q   <= 4'hf;
         col_idx_q  <= '0;
         acc_q      <= '0;
         acc_code_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         row_s1_q <= Row;
         row_s2_q <= row_s1_q;
         if (tick) begin
            col_idx_q  <= col_idx_q + 2'd1;
            acc_q      <= frame_end ? 2'd0 : tot;
            acc_code_q <= frame_end ? 4'd0 : f_code;
         end
      end
   end
   always_ff @(posedge ck or negedge R) begin
      if (!R) begin
         state_q <= IDLE;
         fcnt_q  <= '0;
         cand_q  <= '0;
         Key     <= '0;
         Valid   <= 1'b0;
         Pressed <= 1'b0;
      end else begin
         Valid <= 1'b0;
         if (frame_end)
            case (state_q)
               IDLE:
                  if (one) begin
                     cand_q <= f_code;
                     fcnt_q <= 4'd1;
                     if (DEB == 4'd1) begin
                        Key     <= f_code;
                        Valid   <= 1'b1;
                        Pressed <= 1'b1;
                        state_q <= HELD;
                     end else
                        state_q <= DEB_PRESS;
                  end
               DEB_PRESS:
                  if (one && f_code == cand_q) begin
                     fcnt_q <= fcnt_inc;
                     if (fcnt_inc == DEB) begin
                        Key     <= cand_q;
                        Valid   <= 1'b1;
                        Pressed <= 1'b1;
                        state_q <= HELD;
                     end
                  end else if (one) begin
                     cand_q <= f_code;
                     fcnt_q <= 4'd1;
                  end else
                     state_q <= IDLE;
               HELD:
                  if (none) begin
                     fcnt_q <= 4'd1;
                     if (DEB == 4'd1) begin
                        Pressed <= 1'b0;
                        state_q <= IDLE;
                     end else
                        state_q <= DEB_REL;
                  end
               DEB_REL:
                  if (none) begin
                     fcnt_q <= fcnt_inc;
                     if (fcnt_inc == DEB) begin
                        Pressed <= 1'b0;
                        state_q <= IDLE;
                     end
                  end else
                     state_q <= HELD;
               default: state_q <= IDLE;
            endcase
      end
   end
endmodule

// File: tb/tb_keypad_scan_4x4.sv
// tb_keypad_scan_4x4: directed bench for keypad_scan_4x4 with a behavioural keypad matrix
module tb_keypad_scan_4x4;
   logic        ck = 1'b0;
   logic        R = 1'b0;
   logic [15:0] keys = 16'h0000;
   logic [3:0]  Row, Col, Key;
   logic        Valid, Pressed;
   int          nchk = 0;
   int          nerr = 0;
   int          vcnt = 0;
   int          v0 = 0;
   keypad_scan_4x4 #(.CLK_DIV(8), .DEB_FRAMES(3)) dut (
      .ck(ck), .R(R), .Row(Row), .Col(Col), .Key(Key), .Valid(Valid), .Pressed(Pressed)
   );
   always #5 ck = ~ck;
   // keys bit r*4+c pulls Row[r] low while Col[c] is low
   assign Row = {~|(keys[15:12] & ~Col), ~|(keys[11:8] & ~Col),
                 ~|(keys[7:4] & ~Col), ~|(keys[3:0] & ~Col)};
   always @(negedge ck) if (Valid === 1'b1) vcnt = vcnt + 1;
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic frame();
      repeat (32) @(posedge ck);
      @(negedge ck);
      #1;
   endtask
   initial begin
      logic [3:0] col_seq [4];
      col_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      // reset held with (1,2) pressed
      keys = 16'h0040;
      repeat (10) begin
         @(negedge ck);
         #1;
         chk("rst_col", 16'(Col), 16'h000e);
         chk("rst_key", 16'(Key), 16'h0);
         chk("rst_valid", 16'(Valid), 16'h0);
         chk("rst_pressed", 16'(Pressed), 16'h0);
      end
      keys = 16'h0000;
      R = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("col_step", 16'(Col), 16'(col_seq[i]));
         repeat (8) @(posedge ck);
         @(negedge ck);
         #1;
      end
      // clean press (2,1) for 6 frames
      v0 = vcnt;
      keys = 16'h0200;
      for (int f = 1; f <= 6; f++) begin
         frame();
         chk("press_valid", 16'(Valid), f == 3 ? 16'h1 : 16'h0);
         chk("press_pressed", 16'(Pressed), f >= 3 ? 16'h1 : 16'h0);
         if (f >= 3) chk("press_key", 16'(Key), 16'h9);
      end
      chk("press_vcount", 16'(vcnt - v0), 16'h1);
      // release
      keys = 16'h0000;
      for (int f = 1; f <= 3; f++) begin
         frame();
         chk("rel_pressed", 16'(Pressed), f == 3 ? 16'h0 : 16'h1);
         chk("rel_valid", 16'(Valid), 16'h0);
      end
      chk("rel_key", 16'(Key), 16'h9);
      chk("rel_vcount", 16'(vcnt - v0), 16'h1);
      // bounce (3,3) on alternate frames
      v0 = vcnt;
      for (int f = 0; f < 10; f++) begin
         keys = (f % 2 == 0) ? 16'h8000 : 16'h0000;
         frame();
         chk("bounce_valid", 16'(Valid), 16'h0);
         chk("bounce_pressed", 16'(Pressed), 16'h0);
      end
      chk("bounce_vcount", 16'(vcnt - v0), 16'h0);
      // reset mid-debounce with (1,0)
      keys = 16'h0010;
      frame();
      frame();
      chk("mid_pre_valid", 16'(Valid), 16'h0);
      repeat (10) @(posedge ck);
      @(negedge ck);
      #1;
      R = 1'b0;
      #1;
      chk("mid_rst_col", 16'(Col), 16'h000e);
      chk("mid_rst_key", 16'(Key), 16'h0);
      chk("mid_rst_valid", 16'(Valid), 16'h0);
      chk("mid_rst_pressed", 16'(Pressed), 16'h0);
      repeat (3) @(negedge ck);
      #1;
      R = 1'b1;
      v0 = vcnt;
      for (int f = 1; f <= 3; f++) begin
         frame();
         chk("mid_valid", 16'(Valid), f == 3 ? 16'h1 : 16'h0);
         chk("mid_pressed", 16'(Pressed), f == 3 ? 16'h1 : 16'h0);
         if (f == 2) chk("mid_vcount", 16'(vcnt - v0), 16'h0);
      end
      chk("mid_key", 16'(Key), 16'h4);
      keys = 16'h0000;
      repeat (3) frame();
      chk("mid_rel_pressed", 16'(Pressed), 16'h0);
      // multi-key from IDLE: (0,0)+(0,1)
      v0 = vcnt;
      keys = 16'h0003;
      repeat (4) frame();
      chk("multi_vcount", 16'(vcnt - v0), 16'h0);
      chk("multi_pressed", 16'(Pressed), 16'h0);
      chk("multi_key", 16'(Key), 16'h4);
      // (0,0) accepted, then (2,2) added while held
      keys = 16'h0001;
      repeat (3) frame();
      chk("hold00_valid", 16'(Valid), 16'h1);
      chk("hold00_key", 16'(Key), 16'h0);
      chk("hold00_pressed", 16'(Pressed), 16'h1);
      v0 = vcnt;
      keys = 16'h0401;
      for (int f = 0; f < 3; f++) begin
         frame();
         chk("hold_multi_pressed", 16'(Pressed), 16'h1);
         chk("hold_multi_valid", 16'(Valid), 16'h0);
      end
      chk("hold_multi_vcount", 16'(vcnt - v0), 16'h0);
      chk("hold_multi_key", 16'(Key), 16'h0);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
